// File: rtl/prog_counter_pkg.sv
// Shared types for the programmable up/down counter: count modes and the
// one-shot sequencer states.
package prog_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : prog_counter_pkg

// File: rtl/prog_counter_prescaler.sv
// Step qualifier for prog_counter: passes every PRESCALE-th enabled cycle.
// Only present when PROG_COUNTER_PRESCALE_EN is defined.
`ifdef PROG_COUNTER_PRESCALE_EN
module prog_counter_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic enable_i,
    output logic step_o
);

    localparam int unsigned     CW     = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]   LAST_C = CW'(PRESCALE - 1);
    localparam logic [CW-1:0]   ONE_C  = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A clearing cycle never qualifies a step, so a fresh run always waits a full period.
    assign step_o = enable_i & ~clr_i & (cnt_q == LAST_C);

    // Next enabled-cycle count, wrapping after the qualifying cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CW{1'b0}};
        end else if (enable_i) begin
            cnt_d = (cnt_q == LAST_C) ? {CW{1'b0}} : (cnt_q + ONE_C);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : prog_counter_prescaler
`endif

// File: rtl/prog_counter.sv
// Parametrised up/down counter with programmable limit, load, and
// wrap / saturate / one-shot modes. Optional step prescaler: PROG_COUNTER_PRESCALE_EN.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int unsigned      PRESCALE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic [1:0]       mode,
    input  logic             start,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] clamp_to_limit(
        input logic [WIDTH-1:0] val,
        input logic [WIDTH-1:0] lim
    );
        return (val > lim) ? lim : val;
    endfunction

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    state_e           state_q, state_d;
    state_e           os_state_s;

    mode_e            mode_s;
    logic             oneshot_s;
    logic             step_s;
    logic             at_bound_s;
    logic [WIDTH-1:0] stepped_s;
    logic [WIDTH-1:0] restart_s;

`ifdef PROG_COUNTER_PRESCALE_EN
    logic presc_clr_s;

    assign presc_clr_s = load | start;

    prog_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (presc_clr_s),
        .enable_i (enable),
        .step_o   (step_s)
    );
`else
    assign step_s = enable;
`endif

    // Reserved mode encoding 3 falls into the WRAP branch below.
    assign mode_s     = mode_e'(mode);
    assign oneshot_s  = (mode_s == MODE_ONESHOT);
    // Counting up, any count at or above a (possibly lowered) limit is the boundary.
    assign at_bound_s = up_down ? (count_q >= limit) : (count_q == ZERO_C);
    assign stepped_s  = up_down ? (count_q + ONE_C) : (count_q - ONE_C);
    // Wrap target and one-shot start value coincide: 0 going up, limit going down.
    assign restart_s  = up_down ? ZERO_C : limit;

    // Next count, terminal-count pulse and one-shot sequencing.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        case (state_q)
            ST_RUN, ST_DONE: os_state_s = state_q;
            default:         os_state_s = ST_IDLE;
        endcase

        if (load) begin
            count_d    = clamp_to_limit(load_val, limit);
            os_state_s = ST_IDLE;
        end else if (oneshot_s && start) begin
            count_d    = restart_s;
            os_state_s = ST_RUN;
        end else if (step_s) begin
            case (mode_s)
                MODE_SAT: begin
                    if (at_bound_s) begin
                        tc_d = 1'b1;
                    end else begin
                        count_d = stepped_s;
                    end
                end
                MODE_ONESHOT: begin
                    if (state_q != ST_RUN) begin
                        count_d = count_q;
                    end else if (at_bound_s) begin
                        tc_d       = 1'b1;
                        os_state_s = ST_DONE;
                    end else begin
                        count_d = stepped_s;
                    end
                end
                default: begin
                    if (at_bound_s) begin
                        tc_d    = 1'b1;
                        count_d = restart_s;
                    end else begin
                        count_d = stepped_s;
                    end
                end
            endcase
        end else begin
            count_d = count_q;
        end

        state_d = oneshot_s ? os_state_s : ST_IDLE;
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
    end

    // Count, status and sequencer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_VAL;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            state_q <= state_d;
        end
    end

    assign count_out = count_q;
    assign tc        = tc_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : prog_counter

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_prog_counter;

    localparam int unsigned W        = 8;
    localparam logic [W-1:0] RV      = 8'd3;
    localparam int unsigned PRESCALE = 4;

    logic         clk = 1'b0;
    logic         reset, enable, up_down, load, start;
    logic [W-1:0] load_val, limit;
    logic [1:0]   mode;
    logic [W-1:0] count_out;
    logic         tc, busy, done;

    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;

    // behavioural model of the visible outputs
    int  m_count;
    bit  m_tc, m_run, m_done;
    int  m_pre;

    prog_counter #(
        .WIDTH     (W),
        .RESET_VAL (RV),
        .PRESCALE  (PRESCALE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .up_down   (up_down),
        .load      (load),
        .load_val  (load_val),
        .limit     (limit),
        .mode      (mode),
        .start     (start),
        .count_out (count_out),
        .tc        (tc),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model across one clock edge using the inputs present at that edge.
    task automatic model_step();
        int  lim;
        int  cnt;
        bit  os;
        bit  step;
        bit  atb;
        lim = int'(limit);
        cnt = m_count;
        os  = (mode == 2'd2);
        if (reset) begin
            m_count = int'(RV);
            m_tc    = 1'b0;
            m_run   = 1'b0;
            m_done  = 1'b0;
            m_pre   = 0;
            return;
        end
`ifdef PROG_COUNTER_PRESCALE_EN
        step = 1'b0;
        if (load || start) begin
            m_pre = 0;
        end else if (enable) begin
            m_pre++;
            if (m_pre == PRESCALE) begin
                m_pre = 0;
                step  = 1'b1;
            end
        end
`else
        step = enable;
`endif
        m_tc = 1'b0;
        atb  = up_down ? (cnt >= lim) : (cnt == 0);
        if (load) begin
            m_count = (int'(load_val) < lim) ? int'(load_val) : lim;
            m_run   = 1'b0;
            m_done  = 1'b0;
        end else if (os && start) begin
            m_count = up_down ? 0 : lim;
            m_run   = 1'b1;
            m_done  = 1'b0;
        end else if (step) begin
            if (os) begin
                if (m_run) begin
                    if (atb) begin
                        m_tc   = 1'b1;
                        m_run  = 1'b0;
                        m_done = 1'b1;
                    end else begin
                        m_count = up_down ? cnt + 1 : cnt - 1;
                    end
                end
            end else if (mode == 2'd1) begin
                if (atb) m_tc = 1'b1;
                else     m_count = up_down ? cnt + 1 : cnt - 1;
            end else begin
                if (atb) begin
                    m_tc    = 1'b1;
                    m_count = up_down ? 0 : lim;
                end else begin
                    m_count = up_down ? cnt + 1 : cnt - 1;
                end
            end
        end
        if (!os) begin
            m_run  = 1'b0;
            m_done = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic lit(input string name, input int c, input bit t, input bit b, input bit d);
        check({name, ".count"}, int'(count_out), c);
        check({name, ".tc"},    int'(tc),        int'(t));
        check({name, ".busy"},  int'(busy),      int'(b));
        check({name, ".done"},  int'(done),      int'(d));
    endtask

    // Per-cycle comparison of DUT outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model.count", int'(count_out), m_count);
            check("model.tc",    int'(tc),        int'(m_tc));
            check("model.busy",  int'(busy),      int'(m_run));
            check("model.done",  int'(done),      int'(m_done));
        end
    end

    initial begin
        int exp_wrap [7];
        int exp_wtc  [7];
        int exp_sat  [4];
        int exp_stc  [4];
        int pre_exp;

        exp_wrap = '{1, 2, 3, 4, 5, 0, 1};
        exp_wtc  = '{0, 0, 0, 0, 0, 1, 0};
        exp_sat  = '{1, 0, 0, 0};
        exp_stc  = '{0, 0, 1, 1};

        reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0; start = 1'b0;
        load_val = 8'd0; limit = 8'd5; mode = 2'd0;
        tick();
        tick();
        chk_en = 1'b1;
        lit("reset", int'(RV), 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // wrap up with limit 5
        load = 1'b1; load_val = 8'd0;
        tick();
        lit("wrap.load", 0, 1'b0, 1'b0, 1'b0);
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("wrap.count", int'(count_out), exp_wrap[i]);
            check("wrap.tc",    int'(tc),        exp_wtc[i]);
        end

        // saturate down from 2
        mode = 2'd1; up_down = 1'b0; load = 1'b1; load_val = 8'd2;
        tick();
        lit("sat.load", 2, 1'b0, 1'b0, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("sat.count", int'(count_out), exp_sat[i]);
            check("sat.tc",    int'(tc),        exp_stc[i]);
        end

        // one-shot up to 3
        mode = 2'd2; up_down = 1'b1; limit = 8'd3; enable = 1'b0; start = 1'b1;
        tick();
        lit("os.start", 0, 1'b0, 1'b1, 1'b0);
        start = 1'b0; enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            lit("os.run", i, 1'b0, 1'b1, 1'b0);
        end
        tick();
        lit("os.end", 3, 1'b1, 1'b0, 1'b1);
        tick();
        lit("os.hold", 3, 1'b0, 1'b0, 1'b1);
        start = 1'b1;
        tick();
        lit("os.restart", 0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        tick();
        lit("os.two", 2, 1'b0, 1'b1, 1'b0);

        // reset mid-run
        reset = 1'b1;
        tick();
        lit("os.reset", int'(RV), 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // load clamps to limit and beats enable
        mode = 2'd0; limit = 8'd10; load_val = 8'd200; load = 1'b1; enable = 1'b1;
        tick();
        lit("clamp", 10, 1'b0, 1'b0, 1'b0);

        // prescaled stepping over 12 enabled cycles
        limit = 8'd100; load_val = 8'd0;
        tick();
        load = 1'b0;
        for (int i = 0; i < 12; i++) tick();
`ifdef PROG_COUNTER_PRESCALE_EN
        pre_exp = 3;
`else
        pre_exp = 12;
`endif
        check("prescale.count", int'(count_out), pre_exp);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            start    = ($urandom_range(0, 11) == 0);
            enable   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) up_down = ~up_down;
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0)
                limit = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            tick();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_prog_counter

// File: doc/prog_counter.md
Name: prog_counter

Overview:
Parametrised up/down counter with programmable limit, synchronous load and three count modes: wrap, saturate and one-shot.
- Successor to the fixed 4-bit up counter; used for timers, event counters and tick generators across the design.
- Emits a registered terminal-count pulse, plus busy/done status for one-shot operation.

Parameters:
WIDTH, 8, counter width in bits (>=2)
RESET_VAL, 0, count value loaded on reset (must be <= 2**WIDTH-1)
PRESCALE, 4, step divider used only when PROG_COUNTER_PRESCALE_EN is defined (>=2)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  count-step enable
up_down  input  1  1 = count up, 0 = count down
load  input  1  synchronous load strobe
load_val  input  WIDTH  value for load
limit  input  WIDTH  upper bound; count range is 0..limit
mode  input  2  0 = WRAP, 1 = SATURATE, 2 = ONESHOT, 3 = reserved (behaves as WRAP)
start  input  1  ONESHOT start strobe
count_out  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse (registered)
busy  output  1  ONESHOT run in progress
done  output  1  ONESHOT completed (level)

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All outputs are registered.
- Reset values: count_out=RESET_VAL, tc=0, busy=0, done=0, FSM=IDLE.
- Priority per cycle: reset > load > start > enable step.
- Load: count_out <= min(load_val, limit) next cycle; clears done; FSM -> IDLE; tc=0 that cycle.
- Step (enable=1, no load/start): boundary is count_out>=limit when counting up, count_out==0 when counting down.
  - Not at boundary: +1 or -1.
  - WRAP at boundary: up -> 0, down -> limit.
  - SATURATE at boundary: hold.
  - ONESHOT: steps only in RUN; at boundary it holds and the FSM moves RUN->DONE.
- If limit drops below count_out, count_out>=limit counts as boundary when counting up. When counting down it decrements normally.
- tc=1 for exactly the cycle after any enabled step taken at boundary; otherwise 0. SATURATE held at boundary pulses tc every enabled cycle.
- ONESHOT FSM (mode==2):
  - IDLE: busy=0, done=0, count holds. start -> RUN and count_out <= 0 (up) or limit (down).
  - RUN: busy=1. Steps on enable. Boundary step -> DONE.
  - DONE: busy=0, done=1, count holds. start -> RUN (restart as above); load -> IDLE.
  - start while in RUN restarts the count; the state stays RUN.
- Modes 0/1: FSM forced to IDLE; busy=0, done=0; start ignored.
- A change of mode mid-operation takes effect next cycle. Leaving ONESHOT forces IDLE.
- Arithmetic is modulo 2**WIDTH internally. No result may exceed limit except by a limit change.
- Reset mid-operation aborts everything and restores the reset values above.

Optional Feature:
PROG_COUNTER_PRESCALE_EN
- Defined: an internal prescaler counts enabled cycles; a count step (and any tc) occurs only on every PRESCALE-th enabled cycle. The prescaler clears on reset, load and start.
- Undefined: every enabled cycle is a step; PRESCALE is unused; no prescaler logic is present.

Decomposition:
- prog_counter_pkg:
  - mode enum typedef (MODE_WRAP, MODE_SAT, MODE_ONESHOT)
  - FSM state typedef (ST_IDLE, ST_RUN, ST_DONE)
- Sub-module prog_counter_prescaler: generates the step-qualify signal from enable, with sync clear. It is instantiated only under the macro.

Test Plan:
- WIDTH=8, limit=5, WRAP, up, enable held: count 0,1,2,3,4,5,0; tc=1 in the cycle after the 5->0 step only.
- SATURATE, down, load_val=2: count 2,1,0,0,0; tc=1 on each cycle after a step taken at 0.
- ONESHOT, limit=3, up, start pulse then enable: busy=1 over counts 0..3; then done=1, busy=0, count holds 3; a second start restarts at 0.
- load_val=200 with limit=10: count_out=10. Simultaneous load and enable: load wins.
- Reset asserted in ONESHOT RUN at count 2: next cycle count=RESET_VAL, busy=0, done=0, tc=0.
- With PROG_COUNTER_PRESCALE_EN and PRESCALE=4, enable held for 12 cycles: count advances exactly 3 times.
